// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one shared WIDTH-bit
// register, with a hold timeout so no single owner can starve the others.
module dff_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          q,
  output logic [WIDTH-1:0]          qbar,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      timeout
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [CNTW-1:0] cnt;
  logic            armed;

  // Handshake: a requester holds req high until done; gnt is a registered
  // one-hot that appears the edge after req is sampled, and its write (we)
  // lands in q on every edge where it is granted, including its release edge.

  // Returns {found, index}; lowest circular offset from start wins.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [IDXW-1:0] start);
    logic [IDXW:0] res;
    int            idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NREQ;
      if (cand[idx]) res = {1'b1, IDXW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [IDXW-1:0] next_ptr;
  logic            hold_last;
  logic            forced;
  logic            release_now;
  logic [NREQ-1:0] rel_cand;
  logic [IDXW:0]   idle_pick;
  logic [IDXW:0]   rel_pick;

  always_comb begin
    next_ptr    = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
    hold_last   = (cnt == CNT_LAST);
    forced      = req[owner] && hold_last;
    release_now = !req[owner] || hold_last;
    rel_cand    = req;
    if (forced) rel_cand[owner] = 1'b0;
    idle_pick   = rr_pick(req, ptr);
    rel_pick    = rr_pick(rel_cand, next_ptr);
  end

  // armed keeps the first edge after reset release from issuing a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      armed   <= 1'b0;
      gnt     <= '0;
      owner   <= '0;
      timeout <= 1'b0;
      q       <= '0;
    end else begin
      armed   <= 1'b1;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && idle_pick[IDXW]) begin
            state <= OWN;
            owner <= idle_pick[IDXW-1:0];
            gnt   <= onehot(idle_pick[IDXW-1:0]);
            cnt   <= '0;
          end
        end
        OWN: begin
          if (we[owner]) q <= wdata[owner*WIDTH +: WIDTH];
          if (release_now) begin
            ptr     <= next_ptr;
            cnt     <= '0;
            timeout <= forced;
            if (rel_pick[IDXW]) begin
              owner <= rel_pick[IDXW-1:0];
              gnt   <= onehot(rel_pick[IDXW-1:0]);
            end else begin
              state <= IDLE;
              owner <= '0;
              gnt   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == OWN);
  assign qbar = ~q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_busy_gnt:   assert property (@(posedge clk) disable iff (!reset) busy == (gnt != '0));

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter: the driver pushes hand-computed expected
// outputs per edge, a negedge monitor pops and compares them.
module tb_dff_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout;

  // {gnt[3:0], q[7:0], busy, owner[1:0], timeout}
  logic [15:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dff_reg_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .q(q), .qbar(qbar), .busy(busy), .owner(owner), .timeout(timeout)
  );

  function automatic logic [15:0] pack(input logic [3:0] g, input logic [7:0] qq,
                                       input logic b, input logic [1:0] o,
                                       input logic t);
    return {g, qq, b, o, t};
  endfunction

  // monitor
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e[15:12] || q !== e[11:4] || qbar !== ~e[11:4] ||
          busy !== e[3] || owner !== e[2:1] || timeout !== e[0]) begin
        miscompares++;
        $display("FAIL vec%0d: got gnt=%b q=%h qbar=%h busy=%b owner=%0d timeout=%b, want gnt=%b q=%h qbar=%h busy=%b owner=%0d timeout=%b",
                 vectors, gnt, q, qbar, busy, owner, timeout,
                 e[15:12], e[11:4], ~e[11:4], e[3], e[2:1], e[0]);
      end
    end
  end

  // driver: called at a negedge, applies inputs across one posedge
  task automatic step(input logic [3:0] r, input logic [3:0] w,
                      input logic [31:0] d, input logic [15:0] e);
    req   = r;
    we    = w;
    wdata = d;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rr_data;
    logic [7:0]  slice;
    int          nxt;
    req     = '0;
    we      = '0;
    wdata   = '0;
    rr_data = 32'h44332211;
    reset   = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);

    // reset held two cycles, then idle with no requests
    repeat (2) step(4'b0000, 4'b0000, 32'h0, pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    reset = 1'b1;
    repeat (3) step(4'b0000, 4'b0000, 32'h0, pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));

    // round-robin tie from ptr=0, forced handoff every 4 cycles
    step(4'b1111, 4'b1111, rr_data, pack(4'b0001, 8'h00, 1'b1, 2'd0, 1'b0));
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) begin
        slice = rr_data[o*8 +: 8];
        nxt   = (o + 1) % 4;
        if (c < 3)
          step(4'b1111, 4'b1111, rr_data, pack(4'(1 << o), slice, 1'b1, 2'(o), 1'b0));
        else
          step(4'b1111, 4'b1111, rr_data, pack(4'(1 << nxt), slice, 1'b1, 2'(nxt), 1'b1));
      end
    end
    step(4'b1111, 4'b1111, rr_data, pack(4'b0001, 8'h11, 1'b1, 2'd0, 1'b0));

    // owner 0 drops, 1 takes over; 1 writes, then drops while 3 waits
    step(4'b0010, 4'b0000, 32'h00000000, pack(4'b0010, 8'h11, 1'b1, 2'd1, 1'b0));
    step(4'b1010, 4'b0010, 32'h00005A00, pack(4'b0010, 8'h5A, 1'b1, 2'd1, 1'b0));
    step(4'b1000, 4'b0010, 32'h77006B00, pack(4'b1000, 8'h6B, 1'b1, 2'd3, 1'b0));
    // owner 3 drops: tie among 0..2 resolves from ptr=0; non-owner we ignored
    step(4'b0111, 4'b0111, 32'h00000099, pack(4'b0001, 8'h6B, 1'b1, 2'd0, 1'b0));
    step(4'b0000, 4'b0001, 32'h00000099, pack(4'b0000, 8'h99, 1'b0, 2'd0, 1'b0));

    // lone requester 2 for 10 cycles: timeout, one idle cycle, regrant
    step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0100, 8'h99, 1'b1, 2'd2, 1'b0));
    repeat (3) step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0100, 8'h3C, 1'b1, 2'd2, 1'b0));
    step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0000, 8'h3C, 1'b0, 2'd0, 1'b1));
    step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0100, 8'h3C, 1'b1, 2'd2, 1'b0));
    repeat (3) step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0100, 8'h3C, 1'b1, 2'd2, 1'b0));
    step(4'b0100, 4'b0100, 32'h003C0000, pack(4'b0000, 8'h3C, 1'b0, 2'd0, 1'b1));

    // async reset while requester 2 owns and writes
    step(4'b0100, 4'b0100, 32'h00E70000, pack(4'b0100, 8'h3C, 1'b1, 2'd2, 1'b0));
    step(4'b0100, 4'b0100, 32'h00E70000, pack(4'b0100, 8'hE7, 1'b1, 2'd2, 1'b0));
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.push_back(pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    @(negedge clk);
    step(4'b0100, 4'b0100, 32'h00E70000, pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    reset = 1'b1;
    // first edge after release grants nothing, then arbitration starts at ptr=0
    step(4'b1111, 4'b0000, 32'h0, pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    step(4'b1111, 4'b0000, 32'h0, pack(4'b0001, 8'h00, 1'b1, 2'd0, 1'b0));
    step(4'b0000, 4'b0000, 32'h0, pack(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
      miscompares += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
